// File: rtl/reprog_request_ctrl.sv
// Two-key (ARM/FIRE) guard in front of the ICAP IPROG sequencer, one-shot trigger.
// Optional heartbeat watchdog enabled by defining REPROG_WATCHDOG_EN.
module reprog_request_ctrl #(
  parameter logic [31:0] ARM_KEY      = 32'h4152_4D21,
  parameter logic [31:0] FIRE_KEY     = 32'h4649_5245,
  parameter int unsigned ARM_TIMEOUT  = 125000000,
  parameter int unsigned HOLDOFF      = 1250000,
  parameter int unsigned WDOG_TIMEOUT = 625000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  input  logic [31:0] cmd_data,
`ifdef REPROG_WATCHDOG_EN
  input  logic        heartbeat,
  output logic        wdog_fired,
`endif
  output logic        cmd_ack,
  output logic        cmd_err,
  output logic        trigger,
  output logic [2:0]  state_o,
  output logic        timed_out
);

  localparam int unsigned MAX_AH =
    (ARM_TIMEOUT > HOLDOFF) ? ARM_TIMEOUT : HOLDOFF;
  localparam int unsigned MAXP =
    (MAX_AH > WDOG_TIMEOUT) ? MAX_AH : WDOG_TIMEOUT;
  localparam int CW = $clog2(MAXP + 1);

  localparam logic [CW-1:0] ARM_LOAD  = CW'(ARM_TIMEOUT - 1);
  localparam logic [CW-1:0] HOLD_LOAD = CW'(HOLDOFF - 1);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_ARMED   = 3'd1;
  localparam logic [2:0] S_HOLDOFF = 3'd2;
  localparam logic [2:0] S_FIRE    = 3'd3;
  localparam logic [2:0] S_DONE    = 3'd4;

  logic [2:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          tmo_q, tmo_d;
  logic          ack_q, err_q, trig_q;
  logic          rej;
  logic          wdog_exp;

`ifdef REPROG_WATCHDOG_EN
  localparam int WW = $clog2(WDOG_TIMEOUT + 1);
  localparam logic [WW-1:0] WDOG_LOAD = WW'(WDOG_TIMEOUT - 1);

  logic [WW-1:0] wcnt_q;
  logic          wfired_q;
  logic          wd_live;

  assign wd_live  = (state_q == S_IDLE) || (state_q == S_ARMED);
  assign wdog_exp = wd_live && (wcnt_q == '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      wcnt_q   <= WDOG_LOAD;
      wfired_q <= 1'b0;
    end else begin
      if (heartbeat)
        wcnt_q <= WDOG_LOAD;
      else if (wd_live && wcnt_q != '0)
        wcnt_q <= wcnt_q - 1'b1;
      if (wdog_exp)
        wfired_q <= 1'b1;
    end
  end

  assign wdog_fired = wfired_q;
`else
  assign wdog_exp = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tmo_d   = tmo_q;
    rej     = 1'b1;
    if (wdog_exp) begin
      state_d = S_HOLDOFF;
      cnt_d   = HOLD_LOAD;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (cmd_valid && cmd_data == ARM_KEY) begin
            state_d = S_ARMED;
            cnt_d   = ARM_LOAD;
            tmo_d   = 1'b0;
            rej     = 1'b0;
          end
        end
        S_ARMED: begin
          // Expiry wins over any word arriving in the same cycle
          if (cnt_q == '0) begin
            state_d = S_IDLE;
            tmo_d   = 1'b1;
          end else if (cmd_valid && cmd_data == FIRE_KEY) begin
            state_d = S_HOLDOFF;
            cnt_d   = HOLD_LOAD;
            rej     = 1'b0;
          end else if (cmd_valid && cmd_data == ARM_KEY) begin
            cnt_d = ARM_LOAD;
            rej   = 1'b0;
          end else if (cmd_valid) begin
            state_d = S_IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        S_HOLDOFF: begin
          if (cnt_q == '0) state_d = S_FIRE;
          else             cnt_d   = cnt_q - 1'b1;
        end
        S_FIRE:  state_d = S_DONE;
        S_DONE:  state_d = S_DONE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      tmo_q   <= 1'b0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      trig_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
      ack_q   <= cmd_valid;
      err_q   <= cmd_valid & rej;
      trig_q  <= (state_d == S_FIRE);
    end
  end

  assign cmd_ack   = ack_q;
  assign cmd_err   = err_q;
  assign trigger   = trig_q;
  assign state_o   = state_q;
  assign timed_out = tmo_q;

endmodule

// File: tb/tb_reprog_request_ctrl.sv
// Scoreboard bench for reprog_request_ctrl: queued ack/err/state and
// trigger-cycle expectations, popped by a negedge monitor.
module tb_reprog_request_ctrl;

  localparam logic [31:0] ARM  = 32'h4152_4D21;
  localparam logic [31:0] FIRE = 32'h4649_5245;
  localparam int HOLD = 20;

  typedef struct {
    logic       err;
    logic [2:0] st;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_valid = 1'b0;
  logic [31:0] cmd_data = '0;
  logic        cmd_ack, cmd_err, trigger, timed_out;
  logic [2:0]  state_o;
`ifdef REPROG_WATCHDOG_EN
  logic        heartbeat = 1'b0;
  logic        wdog_fired;
`endif

  exp_t exp_q[$];
  int   trig_q[$];
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;

  reprog_request_ctrl #(
    .ARM_TIMEOUT(100),
    .HOLDOFF(HOLD),
    .WDOG_TIMEOUT(500)
  ) dut (
    .clk(clk),
    .reset(reset),
    .cmd_valid(cmd_valid),
    .cmd_data(cmd_data),
`ifdef REPROG_WATCHDOG_EN
    .heartbeat(heartbeat),
    .wdog_fired(wdog_fired),
`endif
    .cmd_ack(cmd_ack),
    .cmd_err(cmd_err),
    .trigger(trigger),
    .state_o(state_o),
    .timed_out(timed_out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cyc %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: every ack and every trigger pulse must match a queued expectation
  always @(negedge clk) begin
    exp_t x;
    int   tc;
    if (cmd_ack === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("spurious_ack", 1, 0);
      end else begin
        x = exp_q.pop_front();
        check("cmd_err", int'(cmd_err), int'(x.err));
        check("state_after_cmd", int'(state_o), int'(x.st));
      end
    end
    if (trigger === 1'b1) begin
      if (trig_q.size() == 0) begin
        check("unexpected_trigger", 1, 0);
      end else begin
        tc = trig_q.pop_front();
        check("trigger_cycle", cyc, tc);
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] d, input logic e,
                      input logic [2:0] s, input logic t);
    exp_t x;
    x.err = e;
    x.st  = s;
    exp_q.push_back(x);
    cmd_valid = 1'b1;
    cmd_data  = d;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    cmd_data  = '0;
    if (t) trig_q.push_back(cyc + HOLD);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle(2);
    reset = 1'b0;
  endtask

  initial begin
    idle(3);
    reset = 1'b0;
    check("rst_state", int'(state_o), 0);
    check("rst_ack", int'(cmd_ack), 0);
    check("rst_err", int'(cmd_err), 0);
    check("rst_trigger", int'(trigger), 0);
    check("rst_timed_out", int'(timed_out), 0);
`ifdef REPROG_WATCHDOG_EN
    check("rst_wdog_fired", int'(wdog_fired), 0);
`endif

    // Full handshake: ARM, FIRE 10 cycles later, one trigger, then DONE
    send(ARM, 1'b0, 3'd1, 1'b0);
    idle(9);
    send(FIRE, 1'b0, 3'd2, 1'b1);
    idle(25);
    check("done_state", int'(state_o), 4);
    send(32'h1234_5678, 1'b1, 3'd4, 1'b0);
    send(ARM, 1'b1, 3'd4, 1'b0);
    send(FIRE, 1'b1, 3'd4, 1'b0);
    idle(30);

    // FIRE without ARM
    do_reset();
    send(FIRE, 1'b1, 3'd0, 1'b0);
    idle(30);
    check("fire_alone_state", int'(state_o), 0);

    // ARM timeout; FIRE lands exactly on the expiry cycle
    send(ARM, 1'b0, 3'd1, 1'b0);
    idle(99);
    check("armed_last_cycle", int'(state_o), 1);
    check("tmo_before_expiry", int'(timed_out), 0);
    send(FIRE, 1'b1, 3'd0, 1'b0);
    check("expired_state", int'(state_o), 0);
    check("timed_out_set", int'(timed_out), 1);

    // Bad word disarms; re-arm restarts the window; FIRE on last good cycle
    send(ARM, 1'b0, 3'd1, 1'b0);
    check("tmo_cleared", int'(timed_out), 0);
    send(32'h0000_0000, 1'b1, 3'd0, 1'b0);
    idle(48);
    send(ARM, 1'b0, 3'd1, 1'b0);
    check("tmo_still_clear", int'(timed_out), 0);
    idle(98);
    send(FIRE, 1'b0, 3'd2, 1'b1);
    idle(25);
    check("late_fire_done", int'(state_o), 4);

    // Reset in the middle of HOLDOFF aborts the trigger
    do_reset();
    send(ARM, 1'b0, 3'd1, 1'b0);
    send(FIRE, 1'b0, 3'd2, 1'b0);
    idle(10);
    check("in_holdoff", int'(state_o), 2);
    do_reset();
    check("abort_state", int'(state_o), 0);
    check("abort_trigger", int'(trigger), 0);
    idle(200);
    check("abort_idle_state", int'(state_o), 0);

`ifdef REPROG_WATCHDOG_EN
    do_reset();
    for (int i = 0; i < 3; i++) begin
      idle(399);
      heartbeat = 1'b1;
      idle(1);
      heartbeat = 1'b0;
      check("hb_state", int'(state_o), 0);
      check("hb_wdog_fired", int'(wdog_fired), 0);
    end
    trig_q.push_back(cyc + 520);
    idle(510);
    check("wdog_fired", int'(wdog_fired), 1);
    check("wdog_holdoff", int'(state_o), 2);
    idle(20);
    check("wdog_done", int'(state_o), 4);
`endif

    idle(5);
    check("ack_queue_drained", exp_q.size(), 0);
    check("trigger_queue_drained", trig_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
